// File: rtl/float_div.sv
// Iterative IEEE-754 single-precision divider, Q = A / B, fixed 28-cycle
// latency from the start edge to the done pulse, one quotient bit per cycle.
// Ports: clk, rst_n (async, active low), start, A, B -> Q, busy, done,
//        overflow (saturated to +/-inf), div_zero (finite nonzero / 0).
// Build option: FLOAT_DIV_ROUND_EN selects round-to-nearest-even;
//               when undefined the result is truncated toward zero.
module float_div #(
   parameter int ITER = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Q,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        div_zero
);

   typedef enum logic [2:0] {
      IDLE, UNPACK, DIV, NORM, DONE
   } state_t;

   localparam logic [2:0] SP_NONE = 3'd0;
   localparam logic [2:0] SP_NAN  = 3'd1;
   localparam logic [2:0] SP_INF  = 3'd2;
   localparam logic [2:0] SP_DZ   = 3'd3;
   localparam logic [2:0] SP_ZERO = 3'd4;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t state, state_nxt;

   logic [31:0]       a_r, b_r;
   logic              sign_r;
   logic signed [9:0] exp_r;
   logic [24:0]       rem;
   logic [23:0]       dvs;
   logic [25:0]       quo;
   logic [4:0]        cnt;
   logic [2:0]        spc;

   logic accept;
   logic last;

   assign accept = start & ((state == IDLE) | (state == DONE));
   assign last   = (cnt == 5'(ITER - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = UNPACK;
         UNPACK:  state_nxt = DIV;
         DIV:     if (last) state_nxt = NORM;
         NORM:    state_nxt = DONE;
         DONE:    state_nxt = start ? UNPACK : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         UNPACK, DIV, NORM: busy = 1'b1;
         DONE:              done = 1'b1;
         default: ;
      endcase
   end

   // operand classification; exponent 0 covers both zero and denormals
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
   logic [2:0]  spc_nxt;

   assign ea    = a_r[30:23];
   assign eb    = b_r[30:23];
   assign fa    = a_r[22:0];
   assign fb    = b_r[22:0];
   assign nan_a = (ea == 8'hFF) & (|fa);
   assign nan_b = (eb == 8'hFF) & (|fb);
   assign inf_a = (ea == 8'hFF) & ~(|fa);
   assign inf_b = (eb == 8'hFF) & ~(|fb);
   assign zer_a = (ea == 8'h00);
   assign zer_b = (eb == 8'h00);

   always_comb begin
      spc_nxt = SP_NONE;
      if (nan_a | nan_b)
         spc_nxt = SP_NAN;
      else if ((zer_a & zer_b) | (inf_a & inf_b))
         spc_nxt = SP_NAN;
      else if (inf_a)
         spc_nxt = SP_INF;
      else if (zer_b)
         spc_nxt = SP_DZ;
      else if (inf_b | zer_a)
         spc_nxt = SP_ZERO;
   end

   // restoring division step
   logic        ge;
   logic [24:0] diff;

   assign ge   = (rem >= {1'b0, dvs});
   assign diff = ge ? (rem - {1'b0, dvs}) : rem;

   // normalise, optionally round, and pack
   logic signed [9:0] en;
   logic [22:0]       man;
   logic [31:0]       q_nxt;
   logic              ov_nxt;
   logic              dz_nxt;
`ifdef FLOAT_DIV_ROUND_EN
   logic              g, r, st, cy;
`endif

   always_comb begin
      en  = quo[25] ? exp_r : (exp_r - 10'sd1);
      man = quo[25] ? quo[24:2] : quo[23:1];
`ifdef FLOAT_DIV_ROUND_EN
      g   = quo[25] ? quo[1] : quo[0];
      r   = quo[25] ? quo[0] : 1'b0;
      st  = |rem;
      {cy, man} = {1'b0, man} + 24'(g & (r | st | man[0]));
      // mantissa wrapped to 1.0 x 2: bump the exponent
      if (cy) en = en + 10'sd1;
`endif
      q_nxt  = {sign_r, 31'h0};
      ov_nxt = 1'b0;
      dz_nxt = 1'b0;
      if (spc == SP_NAN) begin
         q_nxt = QNAN;
      end else if (spc == SP_INF) begin
         q_nxt = {sign_r, 8'hFF, 23'h0};
      end else if (spc == SP_DZ) begin
         q_nxt  = {sign_r, 8'hFF, 23'h0};
         dz_nxt = 1'b1;
      end else if (spc == SP_ZERO) begin
         q_nxt = {sign_r, 31'h0};
      end else if (en >= 10'sd255) begin
         q_nxt  = {sign_r, 8'hFF, 23'h0};
         ov_nxt = 1'b1;
      end else if (en <= 10'sd0) begin
         q_nxt = {sign_r, 31'h0};
      end else begin
         q_nxt = {sign_r, en[7:0], man};
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         sign_r   <= 1'b0;
         exp_r    <= '0;
         rem      <= '0;
         dvs      <= '0;
         quo      <= '0;
         cnt      <= '0;
         spc      <= SP_NONE;
         Q        <= '0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         if (accept) begin
            a_r      <= A;
            b_r      <= B;
            overflow <= 1'b0;
            div_zero <= 1'b0;
         end
         unique case (state)
            UNPACK: begin
               sign_r <= a_r[31] ^ b_r[31];
               exp_r  <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
               rem    <= {2'b01, fa};
               dvs    <= {1'b1, fb};
               quo    <= '0;
               cnt    <= '0;
               spc    <= spc_nxt;
            end
            DIV: begin
               rem <= diff << 1;
               quo <= {quo[24:0], ge};
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               Q        <= q_nxt;
               overflow <= ov_nxt;
               div_zero <= dz_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/float_div.md
Name: float_div

Overview:
- Iterative IEEE-754 single-precision divider. Computes Q = A / B with a start/done handshake.
- It is the inverse-operation companion to the float add/sub/mul units in the ALU calc datapath.
- One quotient bit is produced per cycle.
- Latency is fixed and independent of operand values, so the ALU control FSM can schedule around it.

Parameters:
- ITER, 26, number of quotient iterations: 24 significand bits plus 2 guard/round bits. Only 26 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; A and B are sampled on the same edge.
- A  input  32  dividend, IEEE-754 single.
- B  input  32  divisor, IEEE-754 single.
- Q  output  32  quotient, IEEE-754 single.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Q and the flags are valid.
- overflow  output  1  exponent overflow; the result saturated to ±inf.
- div_zero  output  1  finite nonzero value divided by zero.

Behaviour:
- Reset (rst_n low, asynchronous): Q=0, busy=0, done=0, overflow=0, div_zero=0, FSM=IDLE. All internal registers are cleared.
- Reset mid-operation aborts the operation. No done pulse is produced for it.

State machine:
- IDLE: start=1 latches A and B, sets busy=1, goes to UNPACK.
- UNPACK (1 cycle):
  - Extract the signs; sign = sA ^ sB.
  - exp = eA - eB + 127, held in a 10-bit signed register.
  - Significands are formed as {1, frac}.
  - Operands with exponent 0 (zero or denormal) are treated as ±0.
  - Classify the special case.
- DIV (ITER cycles): restoring division.
  - rem starts at {1, fracA}.
  - Each cycle: if rem >= divisor, then rem -= divisor and the quotient bit is 1. Then rem <<= 1.
  - Quotient bits shift in MSB-first.
  - The sticky bit is (rem != 0) after the last iteration.
- NORM (1 cycle):
  - If the quotient MSB is 0 (significand ratio < 1), shift left by 1 and decrement exp.
  - If exp >= 255: Q = ±inf (sign, 0xFF, 0), overflow=1.
  - If exp <= 0: Q = ±0 (flush to zero, no flag).
  - Otherwise, pack sign, exp[7:0] and quotient bits [24:2].
- DONE: Q and flags are updated. done=1 for one cycle, busy=0, go to IDLE.

Timing:
- Latency: with start sampled at edge 0, done is high after edge 28 (1 UNPACK + 26 DIV + 1 NORM).
- A back-to-back start is accepted in the cycle done is high.
- start while busy=1 is ignored. The operands are not re-latched.
- Q and the flags hold their value until the next done. The flags are cleared at the start of each new operation.

Special cases (same 28-cycle latency; result forced in NORM, priority top-down):
- Either operand NaN -> 0x7FC00000.
- 0/0 or inf/inf -> 0x7FC00000.
- inf/x -> ±inf.
- finite nonzero / 0 -> ±inf, div_zero=1.
- x/inf or 0/x -> ±0.
- overflow is never set for the special cases.

Optional Feature:
- Macro: FLOAT_DIV_ROUND_EN.
- When defined, NORM applies round-to-nearest-even using guard bit, round bit and sticky bit.
  - A mantissa carry-out increments exp.
  - The overflow check is applied after rounding.
- When undefined, the result is truncated (round toward zero). The guard, round and sticky bits are discarded.
- Latency is identical in both builds.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000 (2.0), start pulse -> done 28 cycles later, Q=0x40400000, overflow=0, div_zero=0.
- A=0x3F800000 (1.0), B=0x40400000 (3.0) -> Q=0x3EAAAAAA without FLOAT_DIV_ROUND_EN; Q=0x3EAAAAAB with it.
- A=0x3F800000, B=0x00000000 -> Q=0x7F800000, div_zero=1. Then A=0, B=0 -> Q=0x7FC00000, div_zero=0.
- A=0x7F000000 (2^127), B=0x3E800000 (0.25) -> Q=0x7F800000, overflow=1. Then A=0x00800000, B=0x7F000000 -> Q=0x00000000.
- Start 6.0/2.0, then pulse start with A=1.0, B=1.0 at cycle 10 -> ignored, Q=0x40400000 at cycle 28. A new start in the done cycle -> its result arrives 28 cycles later.
- Start an operation, drop rst_n at cycle 12 -> all outputs 0 immediately, no done pulse. Release rst_n, start 6.0/2.0 -> correct result after 28 cycles.
